sprite_lane_renderer: RTL and testbench
=======================================

# sprite_lane_renderer

Multi-channel sprite mover/renderer for the 320x240 VGA game. Each frame tick it moves NUM_SPRITES horizontally-moving sprites, each in its own lane, and redraws them. For each channel it erases the old rectangle, applies the clamped move, then redraws from a sprite ROM with transparency. It sits between the tick generator / input logic and the vga_adapter, replacing the single-car control/datapath pair.

## Interface
- NUM_SPRITES, 2: number of channels/lanes (1..8)
- SPRITE_W, 27: sprite width in pixels
- SPRITE_H, 48: sprite height in pixels
- SCREEN_W, 320: screen width; right clamp = SCREEN_W-SPRITE_W
- X_W, 9 / Y_W, 8: coordinate widths
- COLOUR_W, 3: colour bits
- X_INIT, 160: reset x of every channel
- Y_BASE, 190 / LANE_PITCH, 0: channel i drawn at y = Y_BASE - i*LANE_PITCH; elaboration error if any lane leaves 0..239
- SPEED, 1: pixels moved per tick
- BG_COLOUR, 3'b000: erase colour
- TRANSPARENT, 3'b101: ROM colour that suppresses plot
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle start pulse
- dir  in  2*NUM_SPRITES  per-channel direction: 00 none, 01 left, 10 right, 11 = none
- rom_sel  out  clog2(NUM_SPRITES) (min 1)  channel being drawn
- rom_x  out  clog2(SPRITE_W)  sprite-relative column
- rom_y  out  clog2(SPRITE_H)  sprite-relative row
- rom_colour  in  COLOUR_W  ROM data, valid exactly 1 cycle after address
- x  out  X_W  plot column to vga_adapter
- y  out  Y_W  plot row
- colour  out  COLOUR_W  plot colour
- plot  out  1  write enable
- pos_x  out  NUM_SPRITES*X_W  current x per channel, for collision logic
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

## Operation
- Reset: plot=0, x=0, y=0, colour=BG_COLOUR, rom_* = 0, busy=0, done=0, every pos_x = X_INIT, state IDLE.
- States: IDLE, ERASE, MOVE, DRAW, FLUSH, DONE.
- IDLE: a frame_tick latches dir for all channels, sets busy, ch=0, and goes to ERASE. frame_tick outside IDLE is ignored. It is neither queued nor counted.
- ERASE: scans the rectangle row-major (col fastest) at the old pos_x[ch] and lane y. Plots BG_COLOUR for every pixel, 1 pixel/cycle, SPRITE_W*SPRITE_H cycles.
- MOVE (1 cycle, no plot):
  - left: pos_x = (pos_x >= SPEED) ? pos_x-SPEED : 0
  - right: pos_x = min(pos_x+SPEED, SCREEN_W-SPRITE_W)
  - none: unchanged
  - Compute in X_W+1 bits; no wrap-around.
- DRAW: issues rom_x/rom_y/rom_sel row-major, 1 address per cycle. The plot stage is one cycle behind. x = pos_x+rom_x (delayed), y = lane_y+rom_y (delayed), colour = rom_colour. plot = 1 unless rom_colour == TRANSPARENT.
- FLUSH: 1 cycle to emit the last pipelined pixel. Then ch+1 goes to ERASE, or the last channel goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Channels are processed strictly in index order. Erase of ch+1 never starts before draw of ch finishes.
- Reset mid-pass: aborts. plot drops on the cycle after resetn is sampled low, no done is issued, positions return to X_INIT, and the screen is left as-is.

## Timing
- Let P = SPRITE_W*SPRITE_H. Per channel: P (ERASE) + 1 (MOVE) + P (DRAW) + 1 (FLUSH) = 2P+2 cycles.
- First erase plot is on the cycle after the accepted frame_tick.
- done asserts N*(2P+2)+1 cycles after the tick edge; busy is high for exactly N*(2P+2) cycles.
- pos_x[ch] updates at the end of MOVE and is stable otherwise.
- x, y and colour are registered outputs, valid whenever plot=1.

## Structure
- Shared package sprite_pkg:
  - direction constants DIR_NONE/DIR_LEFT/DIR_RIGHT
  - renderer state encoding
  - colour width constant shared with vga glue
- Sub-module rect_scanner: W×H row-major counter with start, col/row outputs, first and last flags. It is instantiated once and reused by ERASE and DRAW.

## Test plan
Bench: SPRITE_W=4, SPRITE_H=3 (P=12), NUM_SPRITES=2, LANE_PITCH=10, model ROM returning 3'b010 except as noted.
- Reset, tick with dir=none → ch0 erases 12 px at x 160..163, y 190..192, colour 0, then redraws the same; ch1 does the same at y 180..182; done exactly 53 cycles after the tick edge.
- Tick with dir ch0=right, ch1=left → ch0 redrawn at x 161..164, ch1 at 159..162; pos_x = {159,161}.
- X_INIT=0, left tick → pos_x stays 0, no underflow. X_INIT=316, right tick → stays 316.
- ROM returns TRANSPARENT at (1,1) → that pixel has no plot; the other 11 draw pixels plot.
- frame_tick pulsed mid-pass → ignored; exactly one done. resetn low during DRAW → plot 0 next cycle, no done, pos_x=160.

Source files
------------

// File: rtl/sprite_pkg.sv
//==============================================================================
// Module      : sprite_pkg
// Description : Shared constants and types for the sprite lane renderer and
//               the VGA glue (direction codes, renderer states, colour width).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sprite_pkg;

  // Colour width shared with the vga_adapter glue
  localparam int SPRITE_COLOUR_W = 3;

  // Per-channel direction codes (2'b11 is treated as "none")
  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // Renderer state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERASE = 3'd1,
    ST_MOVE  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } render_state_e;

  // Counter/select width that never collapses to zero bits
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_lane_renderer_if.sv
//==============================================================================
// Module      : sprite_lane_renderer_if
// Description : Frame-tick/direction inputs, sprite ROM port, VGA plot bus and
//               status outputs of the sprite lane renderer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sprite_lane_renderer_if
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 27,
  parameter int SPRITE_H    = 48,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOUR_W    = SPRITE_COLOUR_W
);
  localparam int SEL_W = clog2_min1(NUM_SPRITES);
  localparam int COL_W = clog2_min1(SPRITE_W);
  localparam int ROW_W = clog2_min1(SPRITE_H);

  logic                         frame_tick;
  logic [2*NUM_SPRITES-1:0]     dir;
  logic [SEL_W-1:0]             rom_sel;
  logic [COL_W-1:0]             rom_x;
  logic [ROW_W-1:0]             rom_y;
  logic [COLOUR_W-1:0]          rom_colour;
  logic [X_W-1:0]               x;
  logic [Y_W-1:0]               y;
  logic [COLOUR_W-1:0]          colour;
  logic                         plot;
  logic [NUM_SPRITES*X_W-1:0]   pos_x;
  logic                         busy;
  logic                         done;

  // Renderer side
  modport slave (
    input  frame_tick, dir, rom_colour,
    output rom_sel, rom_x, rom_y, x, y, colour, plot, pos_x, busy, done
  );

  // Tick source / ROM / VGA side
  modport master (
    output frame_tick, dir, rom_colour,
    input  rom_sel, rom_x, rom_y, x, y, colour, plot, pos_x, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/sprite_lane_renderer_rect_scanner.sv
//==============================================================================
// Module      : rect_scanner
// Description : W x H row-major (column fastest) pixel counter. Wraps back to
//               the origin after the last pixel so it is parked for reuse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rect_scanner #(
  parameter int W     = 27,
  parameter int H     = 48,
  parameter int COL_W = 5,
  parameter int ROW_W = 6
) (
  input  wire logic             clock,
  input  wire logic             resetn,
  input  wire logic             start,
  input  wire logic             en,
  output logic [COL_W-1:0]      col,
  output logic [ROW_W-1:0]      row,
  output logic                  first,
  output logic                  last
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Advance column, carry into row, wrap to origin after the final pixel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == COL_W'(W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col   = col_q;
  assign row   = row_q;
  assign first = (col_q == '0) && (row_q == '0);
  assign last  = (col_q == COL_W'(W - 1)) && (row_q == ROW_W'(H - 1));

endmodule

`default_nettype wire

// File: rtl/sprite_lane_renderer.sv
//==============================================================================
// Module      : sprite_lane_renderer
// Description : Per frame tick, for each lane in order: erase the old sprite
//               rectangle, apply the clamped horizontal move, then redraw the
//               sprite from ROM with transparency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sprite_lane_renderer
  import sprite_pkg::*;
#(
  parameter int                  NUM_SPRITES = 2,
  parameter int                  SPRITE_W    = 27,
  parameter int                  SPRITE_H    = 48,
  parameter int                  SCREEN_W    = 320,
  parameter int                  X_W         = 9,
  parameter int                  Y_W         = 8,
  parameter int                  COLOUR_W    = SPRITE_COLOUR_W,
  parameter int                  X_INIT      = 160,
  parameter int                  Y_BASE      = 190,
  parameter int                  LANE_PITCH  = 0,
  parameter int                  SPEED       = 1,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101
) (
  input  wire logic               clock,
  input  wire logic               resetn,
  sprite_lane_renderer_if.slave   bus
);

  localparam int              SEL_W   = clog2_min1(NUM_SPRITES);
  localparam int              COL_W   = clog2_min1(SPRITE_W);
  localparam int              ROW_W   = clog2_min1(SPRITE_H);
  localparam logic [X_W:0]    X_MAX   = (X_W + 1)'(SCREEN_W - SPRITE_W);
  localparam logic [X_W:0]    SPEED_E = (X_W + 1)'(SPEED);

  // Reject channel counts or lane placements that cannot be drawn on screen
  generate
    if (NUM_SPRITES < 1 || NUM_SPRITES > 8) begin : g_bad_num
      $error("sprite_lane_renderer: NUM_SPRITES must be 1..8");
    end
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_lane_chk
      if ((Y_BASE - gi * LANE_PITCH) < 0 ||
          (Y_BASE - gi * LANE_PITCH + SPRITE_H - 1) > 239) begin : g_bad_lane
        $error("sprite_lane_renderer: lane leaves rows 0..239");
      end
    end
  endgenerate

  render_state_e            state_q, state_d;
  logic [SEL_W-1:0]         ch_q, ch_d;
  logic [2*NUM_SPRITES-1:0] dir_q, dir_d;
  logic [X_W-1:0]           pos_q [NUM_SPRITES];
  logic [X_W-1:0]           pos_d [NUM_SPRITES];
  logic                     drv_q, drv_d;
  logic [X_W-1:0]           dx_q, dx_d;
  logic [Y_W-1:0]           dy_q, dy_d;
  logic                     plot_q, plot_d;
  logic [X_W-1:0]           x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic [COLOUR_W-1:0]      colour_q, colour_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     scan_start, scan_en, scan_first, scan_last;
  logic [COL_W-1:0]         scan_col;
  logic [ROW_W-1:0]         scan_row;
  logic [X_W-1:0]           cur_pos;
  logic [Y_W-1:0]           cur_lane;
  logic [1:0]               cur_dir;
  logic [X_W:0]             pos_ext, moved;

  // Lane row of a channel: lanes stack upwards from Y_BASE
  function automatic logic [Y_W-1:0] lane_y(input logic [SEL_W-1:0] c);
    return Y_W'(Y_BASE - int'(c) * LANE_PITCH);
  endfunction

  // One scanner shared by ERASE and DRAW; it wraps to the origin after each use
  rect_scanner #(
    .W     (SPRITE_W),
    .H     (SPRITE_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (scan_start),
    .en     (scan_en),
    .col    (scan_col),
    .row    (scan_row),
    .first  (scan_first),
    .last   (scan_last)
  );

  assign cur_pos  = pos_q[ch_q];
  assign cur_lane = lane_y(ch_q);
  assign cur_dir  = dir_q[{ch_q, 1'b0} +: 2];

  // Clamped move computed one bit wider so neither edge can wrap
  always_comb begin
    pos_ext = {1'b0, cur_pos};
    moved   = pos_ext;
    case (cur_dir)
      DIR_LEFT:  moved = (pos_ext >= SPEED_E) ? pos_ext - SPEED_E : '0;
      DIR_RIGHT: moved = (pos_ext + SPEED_E > X_MAX) ? X_MAX : pos_ext + SPEED_E;
      default:   moved = pos_ext;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: erase, move, draw, flush per channel, then a one-cycle done
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.frame_tick) state_d = ST_ERASE;
      ST_ERASE: if (scan_last) state_d = ST_MOVE;
      ST_MOVE:  state_d = ST_DRAW;
      ST_DRAW:  if (scan_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = (ch_q == SEL_W'(NUM_SPRITES - 1)) ? ST_DONE : ST_ERASE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values for the current state
  always_comb begin
    ch_d       = ch_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    scan_start = 1'b0;
    scan_en    = 1'b0;
    drv_d      = 1'b0;
    dx_d       = dx_q;
    dy_d       = dy_q;
    plot_d     = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    busy_d     = (state_q == ST_ERASE) || (state_q == ST_MOVE) ||
                 (state_q == ST_DRAW)  || (state_q == ST_FLUSH);
    done_d     = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        scan_start = !scan_first;
        if (bus.frame_tick) begin
          dir_d = bus.dir;
          ch_d  = '0;
        end
      end
      ST_ERASE: begin
        scan_en  = 1'b1;
        plot_d   = 1'b1;
        x_d      = cur_pos + X_W'(scan_col);
        y_d      = cur_lane + Y_W'(scan_row);
        colour_d = BG_COLOUR;
      end
      ST_MOVE: begin
        pos_d[ch_q] = X_W'(moved);
      end
      ST_DRAW: begin
        scan_en = 1'b1;
        drv_d   = 1'b1;
        dx_d    = cur_pos + X_W'(scan_col);
        dy_d    = cur_lane + Y_W'(scan_row);
      end
      ST_FLUSH: begin
        if (ch_q != SEL_W'(NUM_SPRITES - 1)) ch_d = ch_q + 1'b1;
      end
      default: ;
    endcase
    // Plot stage for DRAW: ROM data arrives one cycle after its address
    if (drv_q) begin
      x_d      = dx_q;
      y_d      = dy_q;
      colour_d = bus.rom_colour;
      plot_d   = (bus.rom_colour != TRANSPARENT);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ch_q     <= '0;
      dir_q    <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) pos_q[i] <= X_W'(X_INIT);
      drv_q    <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG_COLOUR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      drv_q    <= drv_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_pos
      assign bus.pos_x[gi*X_W +: X_W] = pos_q[gi];
    end
  endgenerate

  assign bus.rom_sel = ch_q;
  assign bus.rom_x   = scan_col;
  assign bus.rom_y   = scan_row;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_lane_renderer.sv
//==============================================================================
// Module      : tb_sprite_lane_renderer
// Description : Self-checking bench for sprite_lane_renderer with a pixel-list
//               reference model and a registered model sprite ROM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sprite_lane_renderer;

  localparam int NS   = 2;
  localparam int SW   = 4;
  localparam int SH   = 3;
  localparam int P    = SW * SH;
  localparam int XI   = 160;
  localparam int YB   = 190;
  localparam int LP   = 10;
  localparam int XMAX = 320 - SW;
  localparam int PASS = NS * (2 * P + 2);   // busy length, done one cycle later

  typedef struct { int x; int y; int c; } px_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  sprite_lane_renderer_if #(
    .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .X_W(9), .Y_W(8), .COLOUR_W(3)
  ) bus ();

  sprite_lane_renderer #(
    .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(320),
    .X_W(9), .Y_W(8), .COLOUR_W(3), .X_INIT(XI), .Y_BASE(YB),
    .LANE_PITCH(LP), .SPEED(1), .BG_COLOUR(3'b000), .TRANSPARENT(3'b101)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  rom_mode = 0;
  bit  mon_en = 0;

  // Model state
  px_t q[$];
  int  mpos [NS];
  bit  act = 0;
  int  k   = 0;

  // Observations recorded per pass for literal checks
  int  rec_x1, rec_y1, rec_y27, rec_plots, rec_busy, rec_done_k;
  int  n_done = 0;

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic int rom_fn(input int sel, input int cx, input int ry);
    case (rom_mode)
      0:       return 2;
      1:       return (cx == 1 && ry == 1) ? 5 : 2;
      default: return (sel * 5 + cx * 3 + ry * 7) % 8;
    endcase
  endfunction

  // Sprite ROM: data valid one clock after the address
  initial begin
    bus.rom_colour = 3'b000;
    forever begin
      @(posedge clock);
      bus.rom_colour <= 3'(rom_fn(int'(bus.rom_sel), int'(bus.rom_x), int'(bus.rom_y)));
    end
  end

  // Build the full expected plot stream for one accepted tick
  task automatic accept_pass(input logic [2*NS-1:0] d);
    int ly, np, col;
    for (int ch = 0; ch < NS; ch++) begin
      ly = YB - ch * LP;
      for (int r = 0; r < SH; r++)
        for (int c = 0; c < SW; c++) q.push_back('{mpos[ch] + c, ly + r, 0});
      case (d[2*ch +: 2])
        2'b01:   np = (mpos[ch] >= 1) ? mpos[ch] - 1 : 0;
        2'b10:   np = (mpos[ch] + 1 > XMAX) ? XMAX : mpos[ch] + 1;
        default: np = mpos[ch];
      endcase
      mpos[ch] = np;
      for (int r = 0; r < SH; r++)
        for (int c = 0; c < SW; c++) begin
          col = rom_fn(ch, c, r);
          if (col != 5) q.push_back('{np + c, ly + r, col});
        end
    end
  endtask

  // Compare process: check outputs after each edge, then advance the model
  initial begin
    px_t e;
    for (int i = 0; i < NS; i++) mpos[i] = XI;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("busy", int'(bus.busy), int'(act && k >= 1 && k <= PASS));
        chk("done", int'(bus.done), int'(act && k == PASS + 1));
        if (!act || k == PASS + 1)
          for (int i = 0; i < NS; i++) chk("pos_x", int'(bus.pos_x[i*9 +: 9]), mpos[i]);
        if (act && k == 1) chk("first_erase_plot", int'(bus.plot), 1);
        if (bus.plot) begin
          if (q.size() == 0) chk("unexpected_plot", 1, 0);
          else begin
            e = q.pop_front();
            chk("px_x", int'(bus.x), e.x);
            chk("px_y", int'(bus.y), e.y);
            chk("px_colour", int'(bus.colour), e.c);
          end
        end
        if (act && k == PASS + 1) chk("pixels_left", q.size(), 0);
        if (act && k == 1) begin rec_x1 = int'(bus.x); rec_y1 = int'(bus.y); end
        if (act && k == 2 * P + 3) rec_y27 = int'(bus.y);
        if (bus.plot) rec_plots++;
        if (bus.busy) rec_busy++;
        if (bus.done) begin rec_done_k = k; n_done++; end
        // Advance to the next edge using the inputs now presented
        if (!resetn) begin
          act = 0; k = 0; q.delete();
          for (int i = 0; i < NS; i++) mpos[i] = XI;
        end else if (act && k <= PASS) begin
          k++;
        end else if (bus.frame_tick) begin
          accept_pass(bus.dir);
          act = 1; k = 0;
          rec_plots = 0; rec_busy = 0; rec_done_k = -1; rec_x1 = -1; rec_y1 = -1; rec_y27 = -1;
        end else begin
          act = 0;
        end
      end
    end
  end

  task automatic run_pass(input logic [2*NS-1:0] d);
    bit got;
    @(posedge clock); #1;
    bus.dir = d; bus.frame_tick = 1'b1;
    @(posedge clock); #1;
    bus.frame_tick = 1'b0;
    bus.dir = 4'($urandom);
    got = 0;
    for (int i = 0; i < 4 * PASS && !got; i++) begin
      @(negedge clock);
      if (bus.done) got = 1;
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  int nd0;

  initial begin
    bus.frame_tick = 1'b0;
    bus.dir = '0;
    @(posedge clock); #1;
    mon_en = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    // Reset state
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_colour", int'(bus.colour), 0);
    chk("rst_rom_sel", int'(bus.rom_sel), 0);
    chk("rst_rom_x", int'(bus.rom_x), 0);
    chk("rst_rom_y", int'(bus.rom_y), 0);
    chk("rst_pos0", int'(bus.pos_x[8:0]), 160);
    chk("rst_pos1", int'(bus.pos_x[17:9]), 160);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clock); #1;

    // Stationary pass
    run_pass(4'b0000);
    chk("p1_first_x", rec_x1, 160);
    chk("p1_first_y", rec_y1, 190);
    chk("p1_ch1_first_y", rec_y27, 180);
    chk("p1_done_cycle", rec_done_k, 53);
    chk("p1_busy_cycles", rec_busy, 52);
    chk("p1_plots", rec_plots, 48);

    // ch0 right, ch1 left
    run_pass(4'b0110);
    chk("p2_pos0", int'(bus.pos_x[8:0]), 161);
    chk("p2_pos1", int'(bus.pos_x[17:9]), 159);

    // Transparent pixel at (1,1)
    rom_mode = 1;
    run_pass(4'b0000);
    chk("p3_plots", rec_plots, 46);
    rom_mode = 0;

    // Ticks during a pass, including during the done cycle, are ignored
    nd0 = n_done;
    @(posedge clock); #1;
    bus.dir = 4'b0000; bus.frame_tick = 1'b1;
    @(posedge clock); #1; bus.frame_tick = 1'b0;
    repeat (9) @(posedge clock); #1; bus.frame_tick = 1'b1;
    @(posedge clock); #1; bus.frame_tick = 1'b0;
    repeat (42) @(posedge clock); #1; bus.frame_tick = 1'b1;
    @(posedge clock); #1; bus.frame_tick = 1'b0;
    repeat (70) @(posedge clock); #1;
    chk("midtick_done_count", n_done - nd0, 1);

    // Reset during DRAW aborts the pass
    nd0 = n_done;
    @(posedge clock); #1;
    bus.dir = 4'b0110; bus.frame_tick = 1'b1;
    @(posedge clock); #1; bus.frame_tick = 1'b0;
    repeat (17) @(posedge clock); #1; resetn = 1'b0;
    @(posedge clock); #1; resetn = 1'b1;
    repeat (80) @(posedge clock); #1;
    chk("abort_done_count", n_done - nd0, 0);
    chk("abort_pos0", int'(bus.pos_x[8:0]), 160);
    chk("abort_pos1", int'(bus.pos_x[17:9]), 160);

    // Drive both lanes into their clamps
    for (int i = 0; i < 160; i++) run_pass(4'b0110);
    chk("clamp_pos0", int'(bus.pos_x[8:0]), 316);
    chk("clamp_pos1", int'(bus.pos_x[17:9]), 0);
    run_pass(4'b0110);
    chk("clamp2_pos0", int'(bus.pos_x[8:0]), 316);
    chk("clamp2_pos1", int'(bus.pos_x[17:9]), 0);

    // Randomized directions, ROM content and tick spacing
    rom_mode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      run_pass(4'($urandom));
    end

    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
